switch_debounce_3ch: RTL and testbench
======================================

# switch_debounce_3ch

Three-channel input conditioner for the board's push-button/slide switches A, B and C. It synchronises each raw pin to `i_Clk`, filters contact bounce with a per-channel stability counter, and produces:

- clean levels,
- single-cycle press and release strobes,
- a per-channel toggle state.

It sits between the switch pads and downstream LED/LUT logic, which must consume only its outputs, never raw pins.

## Interface

Parameters:

- `DEBOUNCE_LIMIT`, default 250000: consecutive stable cycles required before a level change is accepted (10 ms at 25 MHz). Legal range is 1 to 2^24−1.

Ports:

- `i_Clk`, input, 1 bit: single system clock. All logic is on its rising edge.
- `i_Rst`, input, 1 bit: reset. Synchronous and active-high.
- `i_Switch_A`, input, 1 bit: raw, asynchronous, bouncing switch A pin.
- `i_Switch_B`, input, 1 bit: raw switch B pin.
- `i_Switch_C`, input, 1 bit: raw switch C pin.
- `o_Clean`, output, 3 bits: debounced levels. Bit 0 = A, bit 1 = B, bit 2 = C.
- `o_Press`, output, 3 bits: one-cycle strobe when the matching `o_Clean` bit rises.
- `o_Release`, output, 3 bits: one-cycle strobe when the matching `o_Clean` bit falls.
- `o_Toggle`, output, 3 bits: flips on each press of the matching channel.

## Operation

- **Channels.** The three channels are identical and fully independent. There is no shared state and no priority between them.
- **Synchroniser.** Each channel has a 2-flop chain, `sync1 <= pin` and `sync2 <= sync1`. Only `sync2` feeds the filter.
- **Counter.** Each channel has a counter of width `$clog2(DEBOUNCE_LIMIT+1)`, unsigned.
- **Filter**, evaluated every edge when `i_Rst` = 0:
  - `sync2 == o_Clean[n]`: counter <= 0. This covers no change and a bounce that returned before acceptance.
  - `sync2 != o_Clean[n]` and counter < `DEBOUNCE_LIMIT`−1: counter increments by 1.
  - `sync2 != o_Clean[n]` and counter == `DEBOUNCE_LIMIT`−1: `o_Clean[n]` <= `sync2` and counter <= 0.
- **Counter range.** The counter never exceeds `DEBOUNCE_LIMIT`−1, so no wrap-around is possible.
- **Per-channel state machine.** There are two implicit states per channel:
  - STABLE: counter == 0, `sync2 == clean`.
  - PENDING: counter > 0 or `sync2 != clean`.
  - STABLE→PENDING when `sync2` differs. PENDING→STABLE on acceptance, or on the input returning to `clean`.
- **Strobes.** `o_Press[n]` and `o_Release[n]` are registered. On the same edge that `o_Clean[n]` changes:
  - a rise sets `o_Press[n]` = 1 for exactly that one cycle;
  - a fall sets `o_Release[n]` = 1 for exactly that one cycle;
  - at all other times both are 0;
  - the two are never high together on one channel.
- **Toggle.** `o_Toggle[n]` inverts on the same edge that sets `o_Press[n]`.
- **Reset.** When `i_Rst` = 1 at an edge, all of the following clear to 0 on that edge, overriding any pending acceptance:
  - sync flops, counters, `o_Clean`, `o_Press`, `o_Release`, `o_Toggle`.
- **Reset values.** `o_Clean` = 3'b000, `o_Press` = 3'b000, `o_Release` = 3'b000, `o_Toggle` = 3'b000.
- **After reset.** A switch held high through reset is treated as a fresh press. It produces one `o_Press` pulse and a toggle once the debounce time elapses after reset deasserts.

## Timing

- **Latency.** If a pin change is first captured into `sync1` at edge k and held steady, `o_Clean`, the strobe and `o_Toggle` update at edge k+1+`DEBOUNCE_LIMIT`.
  - For `DEBOUNCE_LIMIT` = 1 this is edge k+2.
- **Pulse rejection.** Any `sync2` excursion shorter than `DEBOUNCE_LIMIT` cycles produces no output change.
- **Pulse acceptance.** An excursion of exactly `DEBOUNCE_LIMIT` cycles is accepted.
- **Bounce restart.** A bounce partway through PENDING restarts the count from 0 on the next differing cycle.
- **Strobe width.** Strobe width is exactly 1 cycle.
- **Minimum spacing.** The minimum spacing between a press strobe and the following release strobe on one channel is `DEBOUNCE_LIMIT` cycles.
- **Simultaneous events.** Simultaneous changes on several channels yield simultaneous strobes, each in its own bit.
- **No combinational paths.** There is no combinational path from any input to any output. All outputs come straight from flops.

## Test plan

All scenarios use `DEBOUNCE_LIMIT` = 4.

- **Reset.** Assert `i_Rst` for 3 cycles with all pins high.
  - During reset, all outputs = 0.
  - After release, `o_Clean` = 3'b111 and `o_Press` = 3'b111 for one cycle at edge k+5.
  - `o_Toggle` = 3'b111.
- **Clean press.** A rises and holds, captured at edge k.
  - `o_Clean[0]` = 1 and `o_Press[0]` = 1 at edge k+5.
  - `o_Press[0]` = 0 at edge k+6.
  - `o_Toggle[0]` = 1.
- **Bounce reject and restart.** A goes high for 3 synced cycles, low for 1, then high steadily.
  - There is no change during the 3-cycle burst.
  - `o_Clean[0]` rises exactly 4 cycles after the final steady-high sample reaches `sync2`.
  - There is exactly one `o_Press[0]` pulse.
- **Release and toggle sequence.** Run two full press/release cycles on B.
  - `o_Release[1]` pulses once per fall, never coincident with `o_Press[1]`.
  - `o_Toggle[1]` goes 0→1→0.
- **Channel independence.** Press A and C on the same edge while B bounces every 2 cycles.
  - `o_Press` = 3'b101 on a single cycle.
  - `o_Clean[1]` stays 0 throughout.
- **Reset mid-operation.** Assert `i_Rst` for 1 cycle while A has counter = 3, pending.
  - No press strobe appears on the reset edge; all outputs = 0.
  - The count restarts, and the acceptance occurs 4 cycles after `sync2` refills.

Source files
------------

// File: rtl/switch_debounce_3ch.sv
// switch_debounce_3ch: three independent switch conditioners.
// Each channel: 2-flop synchroniser -> stability counter -> clean level,
// plus registered press/release strobes and a press-driven toggle.
// All outputs come straight from flops; no input reaches an output
// combinationally.
module switch_debounce_3ch #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_A,
  input  logic       i_Switch_B,
  input  logic       i_Switch_C,
  output logic [2:0] o_Clean,
  output logic [2:0] o_Press,
  output logic [2:0] o_Release,
  output logic [2:0] o_Toggle
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  // Terminal count: the counter never goes past this, so it cannot wrap.
  localparam logic [CW-1:0] LIM_M1 = CW'(DEBOUNCE_LIMIT - 1);

  logic [2:0]         pins;
  logic [2:0]         sync1_q;
  logic [2:0]         sync2_q;
  logic [2:0][CW-1:0] cnt_q;
  logic [2:0][CW-1:0] cnt_d;
  logic [2:0]         clean_q;
  logic [2:0]         clean_d;
  logic [2:0]         accept;
  logic [2:0]         press_q;
  logic [2:0]         press_d;
  logic [2:0]         release_q;
  logic [2:0]         release_d;
  logic [2:0]         toggle_q;
  logic [2:0]         toggle_d;

  assign pins = {i_Switch_C, i_Switch_B, i_Switch_A};

  // State register: synchronisers, counters, clean levels and output flops.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
    end else begin
      sync1_q   <= pins;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  // Next-state filter: STABLE when sync2 matches clean (counter held at 0),
  // PENDING otherwise; acceptance happens at the terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    accept  = '0;
    for (int n = 0; n < 3; n++) begin
      if (sync2_q[n] == clean_q[n]) begin
        // No change, or a bounce that returned before acceptance.
        cnt_d[n] = '0;
      end else if (cnt_q[n] == LIM_M1) begin
        accept[n]  = 1'b1;
        clean_d[n] = sync2_q[n];
        cnt_d[n]   = '0;
      end else begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  // Output next-state: strobes fire only on the accepting edge; the
  // direction of the accepted level picks press or release, so the two
  // can never be high together on one channel.
  always_comb begin
    press_d   = accept & sync2_q;
    release_d = accept & ~sync2_q;
    toggle_d  = toggle_q ^ (accept & sync2_q);
  end

  assign o_Clean   = clean_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Toggle  = toggle_q;

endmodule

// File: tb/tb_switch_debounce_3ch.sv
// Directed bench for switch_debounce_3ch with DEBOUNCE_LIMIT = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// Step t = 1 is the edge that first captures a new pin level into sync1,
// so a steady change is accepted on step t = LIMIT + 2 = 6.
module tb_switch_debounce_3ch;

  localparam int LIMIT = 4;
  localparam int ACC   = LIMIT + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_a;
  logic       sw_b;
  logic       sw_c;
  logic [2:0] o_clean;
  logic [2:0] o_press;
  logic [2:0] o_release;
  logic [2:0] o_toggle;

  int checks = 0;
  int errors = 0;

  switch_debounce_3ch #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Switch_A(sw_a),
    .i_Switch_B(sw_b),
    .i_Switch_C(sw_c),
    .o_Clean   (o_clean),
    .o_Press   (o_press),
    .o_Release (o_release),
    .o_Toggle  (o_toggle)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then compare every output against the expected set.
  task automatic step_check(input string tag, input logic [2:0] ec, input logic [2:0] ep,
                            input logic [2:0] er, input logic [2:0] et);
    @(posedge clk);
    #1;
    check({tag, "_clean"},   {29'd0, o_clean},   {29'd0, ec});
    check({tag, "_press"},   {29'd0, o_press},   {29'd0, ep});
    check({tag, "_release"}, {29'd0, o_release}, {29'd0, er});
    check({tag, "_toggle"},  {29'd0, o_toggle},  {29'd0, et});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step_check("in_reset", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
  endtask

  task automatic set_pins(input logic [2:0] p);
    sw_a = p[0];
    sw_b = p[1];
    sw_c = p[2];
  endtask

  initial begin
    rst = 1'b1;
    set_pins(3'b000);
    #1;

    // Reset with all pins high: fresh press on every channel afterwards.
    set_pins(3'b111);
    do_reset(3);
    for (int t = 1; t <= ACC + 1; t++)
      step_check("rst_all_high", (t >= ACC) ? 3'b111 : 3'b000,
                 (t == ACC) ? 3'b111 : 3'b000, 3'b000,
                 (t >= ACC) ? 3'b111 : 3'b000);

    // Clean press on A.
    set_pins(3'b000);
    do_reset(1);
    set_pins(3'b001);
    for (int t = 1; t <= ACC + 1; t++)
      step_check("press_a", (t >= ACC) ? 3'b001 : 3'b000,
                 (t == ACC) ? 3'b001 : 3'b000, 3'b000,
                 (t >= ACC) ? 3'b001 : 3'b000);

    // Bounce on A: 3 high, 1 low, then steady high; accepted 4 edges
    // after the last steady sample reaches sync2 (step 10).
    set_pins(3'b000);
    do_reset(1);
    for (int t = 1; t <= 13; t++) begin
      set_pins((t == 4) ? 3'b000 : 3'b001);
      step_check("bounce_a", (t >= 10) ? 3'b001 : 3'b000,
                 (t == 10) ? 3'b001 : 3'b000, 3'b000,
                 (t >= 10) ? 3'b001 : 3'b000);
    end

    // Two full press/release cycles on B: toggle goes 0 -> 1 -> 0.
    set_pins(3'b000);
    do_reset(1);
    for (int cyc = 0; cyc < 2; cyc++) begin
      logic [2:0] tog_before;
      logic [2:0] tog_after;
      tog_before = (cyc == 0) ? 3'b000 : 3'b010;
      tog_after  = (cyc == 0) ? 3'b010 : 3'b000;
      set_pins(3'b010);
      for (int t = 1; t <= 8; t++)
        step_check("b_press", (t >= ACC) ? 3'b010 : 3'b000,
                   (t == ACC) ? 3'b010 : 3'b000, 3'b000,
                   (t >= ACC) ? tog_after : tog_before);
      set_pins(3'b000);
      for (int t = 1; t <= 8; t++)
        step_check("b_release", (t >= ACC) ? 3'b000 : 3'b010, 3'b000,
                   (t == ACC) ? 3'b010 : 3'b000, tog_after);
    end

    // A and C together while B bounces in 2-cycle runs that never qualify.
    set_pins(3'b000);
    do_reset(1);
    for (int t = 1; t <= 12; t++) begin
      set_pins({1'b1, ((t / 2) % 2) == 1, 1'b1});
      step_check("indep", (t >= ACC) ? 3'b101 : 3'b000,
                 (t == ACC) ? 3'b101 : 3'b000, 3'b000,
                 (t >= ACC) ? 3'b101 : 3'b000);
    end

    // Reset on the edge that would have accepted A; count then restarts.
    set_pins(3'b000);
    do_reset(1);
    set_pins(3'b001);
    for (int t = 1; t < ACC; t++)
      step_check("mid_pending", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b1;
    step_check("mid_rst_edge", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    for (int t = 1; t <= ACC + 1; t++)
      step_check("after_mid_rst", (t >= ACC) ? 3'b001 : 3'b000,
                 (t == ACC) ? 3'b001 : 3'b000, 3'b000,
                 (t >= ACC) ? 3'b001 : 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
